histogram_scheduler: RTL and testbench

HISTOGRAM_SCHEDULER -- requirements
Module: histogram_scheduler

---
 rtl/histogram_scheduler.sv | 169 ++++++++++++++++
 tb/tb_histogram_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_scheduler.sv
// Frame scheduler in front of a histogram: arbitrates two sample sources into spaced
// store pulses, then runs one readout per frame and streams the bins back out.
module histogram_scheduler #(
  parameter int SPECTRUM_WIDTH = 7,
  parameter int STORE_SPACING  = 4,
  parameter int READY_TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [15:0]               frameSamples,
  input  logic                      aValid,
  input  logic [SPECTRUM_WIDTH-1:0] aData,
  output logic                      aReady,
  input  logic                      bValid,
  input  logic [SPECTRUM_WIDTH-1:0] bData,
  output logic                      bReady,
  output logic                      store,
  output logic [SPECTRUM_WIDTH-1:0] inputValue,
  output logic                      startReadout,
  input  logic                      histogramValueReady,
  input  logic [SPECTRUM_WIDTH-1:0] histogramValue,
  output logic                      binValid,
  output logic [SPECTRUM_WIDTH-1:0] binIndex,
  output logic [SPECTRUM_WIDTH-1:0] binCount,
  output logic                      frameDone,
  output logic [15:0]               frameCount,
  output logic                      readoutError
);

  localparam int GW = $clog2(STORE_SPACING);
  localparam int TW = $clog2(READY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ACQUIRE, GAP, READOUT_REQ, READOUT, DONE} state_t;

  state_t                    state_q;
  logic [15:0]               sample_cnt_q;
  logic [GW-1:0]             gap_q;
  logic [TW-1:0]             wait_q;
  logic [SPECTRUM_WIDTH-1:0] beat_q;
  logic                      prefer_a_q;
  logic                      store_q;
  logic [SPECTRUM_WIDTH-1:0] input_value_q;
  logic                      start_q;
  logic                      bin_valid_q;
  logic [SPECTRUM_WIDTH-1:0] bin_index_q;
  logic [SPECTRUM_WIDTH-1:0] bin_count_q;
  logic                      frame_done_q;
  logic [15:0]               frame_count_q;
  logic                      error_q;

  logic acq_open_d;
  logic grant_a_d;
  logic grant_b_d;

  // Round-robin: a lone requester always wins; on contention the pointer decides.
  assign acq_open_d = (state_q == ACQUIRE) && (sample_cnt_q < frameSamples);
  assign grant_a_d  = aValid & (~bValid | prefer_a_q);
  assign grant_b_d  = bValid & (~aValid | ~prefer_a_q);
  assign aReady     = acq_open_d & grant_a_d;
  assign bReady     = acq_open_d & grant_b_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      gap_q         <= '0;
      wait_q        <= '0;
      beat_q        <= '0;
      prefer_a_q    <= 1'b1;
      store_q       <= 1'b0;
      input_value_q <= '0;
      start_q       <= 1'b0;
      bin_valid_q   <= 1'b0;
      bin_index_q   <= '0;
      bin_count_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      error_q       <= 1'b0;
    end else begin
      store_q      <= 1'b0;
      start_q      <= 1'b0;
      bin_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q      <= ACQUIRE;
            sample_cnt_q <= '0;
          end
        end
        ACQUIRE: begin
          // >= rather than == so a frameSamples shrink below the count cannot stall.
          if (sample_cnt_q >= frameSamples) begin
            state_q <= READOUT_REQ;
            start_q <= 1'b1;
            wait_q  <= '0;
          end else if (aValid && aReady) begin
            input_value_q <= aData;
            store_q       <= 1'b1;
            sample_cnt_q  <= sample_cnt_q + 16'd1;
            prefer_a_q    <= 1'b0;
            gap_q         <= '0;
            state_q       <= GAP;
          end else if (bValid && bReady) begin
            input_value_q <= bData;
            store_q       <= 1'b1;
            sample_cnt_q  <= sample_cnt_q + 16'd1;
            prefer_a_q    <= 1'b1;
            gap_q         <= '0;
            state_q       <= GAP;
          end
        end
        GAP: begin
          if (gap_q == GW'(STORE_SPACING - 2)) state_q <= ACQUIRE;
          else gap_q <= gap_q + GW'(1);
        end
        READOUT_REQ: begin
          if (histogramValueReady) begin
            bin_valid_q <= 1'b1;
            bin_count_q <= histogramValue;
            bin_index_q <= '0;
            beat_q      <= SPECTRUM_WIDTH'(1);
            state_q     <= READOUT;
          end else if (wait_q == TW'(READY_TIMEOUT - 1)) begin
            error_q       <= 1'b1;
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            state_q       <= DONE;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        READOUT: begin
          if (histogramValueReady) begin
            bin_valid_q <= 1'b1;
            bin_count_q <= histogramValue;
            bin_index_q <= beat_q;
            beat_q      <= beat_q + SPECTRUM_WIDTH'(1);
          end else begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          if (enable) begin
            state_q      <= ACQUIRE;
            sample_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign store        = store_q;
  assign inputValue   = input_value_q;
  assign startReadout = start_q;
  assign binValid     = bin_valid_q;
  assign binIndex     = bin_index_q;
  assign binCount     = bin_count_q;
  assign frameDone    = frame_done_q;
  assign frameCount   = frame_count_q;
  assign readoutError = error_q;

endmodule

// File: tb/tb_histogram_scheduler.sv
// Directed bench for histogram_scheduler: scoreboard queues for store values and
// readout beats, checked by a negedge monitor, plus directed checks of control outputs.
module tb_histogram_scheduler;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [15:0]  frameSamples;
  logic         aValid, bValid;
  logic [W-1:0] aData, bData;
  logic         aReady, bReady;
  logic         store;
  logic [W-1:0] inputValue;
  logic         startReadout;
  logic         histogramValueReady;
  logic [W-1:0] histogramValue;
  logic         binValid;
  logic [W-1:0] binIndex, binCount;
  logic         frameDone;
  logic [15:0]  frameCount;
  logic         readoutError;

  histogram_scheduler #(.SPECTRUM_WIDTH(W), .STORE_SPACING(4), .READY_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frameSamples(frameSamples),
    .aValid(aValid), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bData(bData), .bReady(bReady),
    .store(store), .inputValue(inputValue), .startReadout(startReadout),
    .histogramValueReady(histogramValueReady), .histogramValue(histogramValue),
    .binValid(binValid), .binIndex(binIndex), .binCount(binCount),
    .frameDone(frameDone), .frameCount(frameCount), .readoutError(readoutError)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int idx; int cnt; } bin_t;

  logic [W-1:0] exp_store[$];
  bin_t         exp_bins[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int n_start  = 0;
  int n_store  = 0;
  int n_bins   = 0;
  int since_store = 1000;
  logic [W-1:0] mon_v;
  bin_t         mon_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (store) begin
      n_store++;
      chk("store_spacing", (since_store + 1 >= 4), 1'b1);
      if (exp_store.size() == 0) chk("store_unexpected", 1, 0);
      else begin
        mon_v = exp_store.pop_front();
        chk("store_value", inputValue, mon_v);
      end
      since_store = 0;
    end else if (since_store < 1000) begin
      since_store++;
    end
    if (binValid) begin
      n_bins++;
      if (exp_bins.size() == 0) chk("bin_unexpected", 1, 0);
      else begin
        mon_b = exp_bins.pop_front();
        chk("bin_index", binIndex, mon_b.idx);
        chk("bin_count", binCount, mon_b.cnt);
        chk("bin_latency", cycle, mon_b.cyc);
      end
    end
    if (startReadout) n_start++;
  end

  task automatic chk_reset(input string t);
    #1;
    chk({t, "_store"}, store, 0);
    chk({t, "_start"}, startReadout, 0);
    chk({t, "_aReady"}, aReady, 0);
    chk({t, "_bReady"}, bReady, 0);
    chk({t, "_inputValue"}, inputValue, 0);
    chk({t, "_binValid"}, binValid, 0);
    chk({t, "_binIndex"}, binIndex, 0);
    chk({t, "_binCount"}, binCount, 0);
    chk({t, "_frameDone"}, frameDone, 0);
    chk({t, "_frameCount"}, frameCount, 0);
    chk({t, "_readoutError"}, readoutError, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_store.delete();
    exp_bins.delete();
  endtask

  // Starts a frame; enable is dropped after one cycle so the frame ends in IDLE.
  task automatic start_frame(input logic [15:0] fs);
    frameSamples = fs;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic send(input bit use_b, input logic [W-1:0] d);
    bit got = 0;
    if (use_b) begin bValid = 1'b1; bData = d; end
    else begin aValid = 1'b1; aData = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (use_b ? bReady : aReady) begin
        exp_store.push_back(d);
        got = 1;
      end
      @(negedge clk);
    end
    aValid = 1'b0;
    bValid = 1'b0;
    chk(use_b ? "send_b_accept" : "send_a_accept", got, 1);
  endtask

  task automatic wait_start(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (startReadout) ok = 1;
    end
    chk("start_seen", ok, 1);
  endtask

  task automatic drive_beat(input int idx, input logic [W-1:0] v);
    bin_t b;
    histogramValueReady = 1'b1;
    histogramValue = v;
    b.cyc = cycle + 1;
    b.idx = idx % 128;
    b.cnt = v;
    exp_bins.push_back(b);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    int k;
    bit last_b;
    logic [W-1:0] vals [3];
    reset = 1'b0; enable = 1'b0; frameSamples = 16'd0;
    aValid = 1'b1; bValid = 1'b1; aData = '0; bData = '0;
    histogramValueReady = 1'b0; histogramValue = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    aValid = 1'b0; bValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Frame of three samples from A, then a three-beat readout.
    s0 = n_start;
    start_frame(16'd3);
    send(0, 7'd5);
    send(0, 7'd6);
    send(0, 7'd7);
    wait_start(20);
    vals[0] = 7'h55; vals[1] = 7'h2A; vals[2] = 7'h11;
    for (int i = 0; i < 3; i++) drive_beat(i, vals[i]);
    histogramValueReady = 1'b0;
    @(negedge clk);
    chk("t1_frameDone", frameDone, 1);
    chk("t1_frameCount", frameCount, 1);
    chk("t1_store_count", n_store, 3);
    chk("t1_start_pulses", n_start - s0, 1);
    @(negedge clk);
    chk("t1_frameDone_one_cycle", frameDone, 0);

    // Both requesters contending: alternate grants starting with A.
    do_reset();
    frameSamples = 16'd4;
    start_frame(16'd4);
    aValid = 1'b1; bValid = 1'b1; aData = 7'h10; bData = 7'h20;
    k = 0;
    last_b = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      #1;
      if (aReady || bReady) begin
        chk("rr_one_ready", aReady & bReady, 0);
        chk($sformatf("rr_grant_%0d_isB", k), bReady, k % 2);
        last_b = bReady;
        exp_store.push_back(bReady ? bData : aData);
        k++;
        @(negedge clk);
        if (last_b) bData = bData + 7'd1;
        else aData = aData + 7'd1;
      end else begin
        @(negedge clk);
      end
    end
    chk("rr_grants", k, 4);
    wait_start(20);
    chk("bp_aReady", aReady, 0);
    chk("bp_bReady", bReady, 0);

    // No readout response: timeout after 16 cycles.
    repeat (15) @(negedge clk);
    chk("to_err_early", readoutError, 0);
    chk("to_bp_aReady", aReady, 0);
    @(negedge clk);
    chk("to_err", readoutError, 1);
    chk("to_frameDone", frameDone, 1);
    chk("to_frameCount", frameCount, 1);
    aValid = 1'b0; bValid = 1'b0;
    repeat (4) @(negedge clk);
    chk("to_err_sticky", readoutError, 1);
    chk("rr_store_count", n_store, 7);

    // Empty frame with a 128-beat readout; error flag stays set.
    s0 = n_bins;
    start_frame(16'd0);
    @(negedge clk);
    chk("empty_start_latency", startReadout, 1);
    for (int i = 0; i < 128; i++) drive_beat(i, W'(i));
    histogramValueReady = 1'b0;
    @(negedge clk);
    chk("ro_frameDone", frameDone, 1);
    chk("ro_frameCount", frameCount, 2);
    chk("ro_binValid_off", binValid, 0);
    chk("ro_beats", n_bins - s0, 128);
    chk("ro_err_sticky", readoutError, 1);
    chk("empty_no_store", n_store, 7);

    // Reset in the middle of GAP.
    start_frame(16'd2);
    send(0, 7'h33);
    reset = 1'b0;
    aValid = 1'b1; bValid = 1'b1;
    @(negedge clk);
    chk_reset("rst_gap");
    reset = 1'b1;
    exp_store.delete();
    s0 = n_start;
    k = n_store;
    repeat (8) @(negedge clk);
    #1;
    chk("rst_gap_idle_aReady", aReady, 0);
    chk("rst_gap_no_start", n_start - s0, 0);
    chk("rst_gap_no_store", n_store - k, 0);
    aValid = 1'b0; bValid = 1'b0;

    // Reset in the middle of READOUT.
    start_frame(16'd0);
    wait_start(10);
    for (int i = 0; i < 3; i++) drive_beat(i, W'(100 + i));
    reset = 1'b0;
    @(negedge clk);
    chk_reset("rst_ro");
    histogramValueReady = 1'b0;
    reset = 1'b1;
    s0 = n_start;
    repeat (6) @(negedge clk);
    chk("rst_ro_no_start", n_start - s0, 0);
    chk("rst_ro_binValid", binValid, 0);

    chk("sb_store_empty", exp_store.size(), 0);
    chk("sb_bins_empty", exp_bins.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
